// File: rtl/pong_game_ctl_pkg.sv
// Shared types and constants for the Pong game-flow controller.
package pong_pkg;

    // Match state encoding; values 5..7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    // Winner codes driven to the score renderer.
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Serve direction: toward the left (P1) or right (P2) player.
    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/pong_game_ctl_if.sv
// Signal bundle between the game-flow controller and its surroundings
// (frame timing, ball/paddle controllers, score renderer).
interface pong_game_ctl_if #(
    parameter int SCORE_W = 4
);
    logic               Game_Start_i;
    logic               Frame_Tick_i;
    logic               Miss_P1_i;
    logic               Miss_P2_i;
    logic               Ball_Active_o;
    logic               Ball_Reset_o;
    logic               Serve_Dir_o;
    logic [SCORE_W-1:0] Score_P1_o;
    logic [SCORE_W-1:0] Score_P2_o;
    logic [1:0]         Winner_o;
    logic [2:0]         State_o;

    // Controller side.
    modport slave (
        input  Game_Start_i, Frame_Tick_i, Miss_P1_i, Miss_P2_i,
        output Ball_Active_o, Ball_Reset_o, Serve_Dir_o,
               Score_P1_o, Score_P2_o, Winner_o, State_o
    );

    // Environment side.
    modport master (
        output Game_Start_i, Frame_Tick_i, Miss_P1_i, Miss_P2_i,
        input  Ball_Active_o, Ball_Reset_o, Serve_Dir_o,
               Score_P1_o, Score_P2_o, Winner_o, State_o
    );
endinterface

// File: rtl/pong_game_ctl_timer.sv
// Frame-tick delay counter: counts ticks up to a programmable limit and
// pulses done on the tick that completes the delay, clearing itself.
module pong_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q;

    assign done = tick && (cnt_q == (limit - CNT_W'(1)));

    // Tick counter; cleared when idle, by request, or on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= done ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pong_game_ctl.sv
// Pong match controller: serve/play/point/over flow, score keeping and
// Moore-style registered outputs for the ball controller and renderer.
module pong_game_ctl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int CNT_W        = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pong_game_ctl_if.slave bus
);
    if (WIN_SCORE < 1 || WIN_SCORE >= 2**SCORE_W) begin : g_bad_win
        $error("WIN_SCORE must be in 1..2**SCORE_W-1");
    end
    if (SERVE_FRAMES < 1 || SERVE_FRAMES >= 2**CNT_W) begin : g_bad_serve
        $error("SERVE_FRAMES must be in 1..2**CNT_W-1");
    end
    if (POINT_FRAMES < 1 || POINT_FRAMES >= 2**CNT_W) begin : g_bad_point
        $error("POINT_FRAMES must be in 1..2**CNT_W-1");
    end

    state_e             state_q;
    logic [SCORE_W-1:0] score_p1_q, score_p2_q;
    logic [1:0]         winner_q;
    logic               active_q, ball_rst_q, dir_q;

    // Increments are one bit wider so the win compare cannot alias on wrap.
    logic [SCORE_W:0]   score_p1_d, score_p2_d;
    logic               timing_st, tmr_done;
    logic [CNT_W-1:0]   tmr_limit;

    assign score_p1_d = {1'b0, score_p1_q} + (SCORE_W+1)'(1);
    assign score_p2_d = {1'b0, score_p2_q} + (SCORE_W+1)'(1);

    // Only SERVE and POINT consume frame ticks; elsewhere the timer is held clear.
    assign timing_st = (state_q == SERVE) || (state_q == POINT);
    assign tmr_limit = (state_q == POINT) ? CNT_W'(POINT_FRAMES) : CNT_W'(SERVE_FRAMES);

    pong_frame_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (!timing_st),
        .tick  (bus.Frame_Tick_i && timing_st),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    // Match FSM with score counters and registered ball-control outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            winner_q   <= WIN_NONE;
            active_q   <= 1'b0;
            ball_rst_q <= 1'b1;
            dir_q      <= DIR_P1;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    if (bus.Game_Start_i) begin
                        state_q    <= SERVE;
                        score_p1_q <= '0;
                        score_p2_q <= '0;
                        winner_q   <= WIN_NONE;
                        dir_q      <= DIR_P1;
                    end
                end
                SERVE: begin
                    if (tmr_done) begin
                        state_q    <= PLAY;
                        active_q   <= 1'b1;
                        ball_rst_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (bus.Miss_P1_i || bus.Miss_P2_i) begin
                        active_q   <= 1'b0;
                        ball_rst_q <= 1'b1;
                        state_q    <= POINT;
                        if (bus.Miss_P1_i && !bus.Miss_P2_i) begin
                            score_p2_q <= score_p2_d[SCORE_W-1:0];
                            dir_q      <= DIR_P1;
                            if (score_p2_d == (SCORE_W+1)'(WIN_SCORE)) begin
                                state_q  <= OVER;
                                winner_q <= WIN_P2;
                            end
                        end else if (bus.Miss_P2_i && !bus.Miss_P1_i) begin
                            score_p1_q <= score_p1_d[SCORE_W-1:0];
                            dir_q      <= DIR_P2;
                            if (score_p1_d == (SCORE_W+1)'(WIN_SCORE)) begin
                                state_q  <= OVER;
                                winner_q <= WIN_P1;
                            end
                        end
                    end
                end
                POINT: begin
                    if (tmr_done) begin
                        state_q <= SERVE;
                    end
                end
                default: begin
                    // Corrupted encoding: fall back to IDLE but keep the scores.
                    state_q    <= IDLE;
                    winner_q   <= WIN_NONE;
                    active_q   <= 1'b0;
                    ball_rst_q <= 1'b1;
                    dir_q      <= DIR_P1;
                end
            endcase
        end
    end

    assign bus.State_o       = state_q;
    assign bus.Score_P1_o    = score_p1_q;
    assign bus.Score_P2_o    = score_p2_q;
    assign bus.Winner_o      = winner_q;
    assign bus.Ball_Active_o = active_q;
    assign bus.Ball_Reset_o  = ball_rst_q;
    assign bus.Serve_Dir_o   = dir_q;
endmodule

// File: tb/tb_pong_game_ctl.sv
// Scoreboard bench for pong_game_ctl with SERVE_FRAMES=2, POINT_FRAMES=3,
// WIN_SCORE=3: stimulus pushes the expected post-edge snapshot, a monitor
// pops and compares it on the following falling edge.
module tb_pong_game_ctl;
    import pong_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
        logic       act;
        logic       brst;
        logic       dir;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pong_game_ctl_if #(.SCORE_W(4)) bus ();

    pong_game_ctl #(
        .WIN_SCORE    (3),
        .SCORE_W      (4),
        .SERVE_FRAMES (2),
        .POINT_FRAMES (3),
        .CNT_W        (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d p1=%0d p2=%0d win=%0d act=%b brst=%b dir=%b",
                         s.st, s.s1, s.s2, s.win, s.act, s.brst, s.dir);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic st, input logic tk,
                       input logic m1, input logic m2, input string nm,
                       input logic [2:0] es, input logic [3:0] e1,
                       input logic [3:0] e2, input logic [1:0] ew,
                       input logic ed);
        exp_t e;
        rst              = r;
        bus.Game_Start_i = st;
        bus.Frame_Tick_i = tk;
        bus.Miss_P1_i    = m1;
        bus.Miss_P2_i    = m2;
        @(posedge clk);
        #1;
        e.name   = nm;
        e.s.st   = es;
        e.s.s1   = e1;
        e.s.s2   = e2;
        e.s.win  = ew;
        e.s.act  = (es == 3'd2);
        e.s.brst = (es != 3'd2);
        e.s.dir  = ed;
        exp_q.push_back(e);
    endtask

    task automatic serve_play(input logic [3:0] a, input logic [3:0] b, input logic d);
        cyc(0, 0, 1, 0, 0, "serve_tick1", SERVE, a, b, WIN_NONE, d);
        cyc(0, 0, 1, 0, 0, "serve_tick2", PLAY,  a, b, WIN_NONE, d);
    endtask

    task automatic point_serve(input logic [3:0] a, input logic [3:0] b, input logic d);
        cyc(0, 0, 1, 0, 0, "point_tick1", POINT, a, b, WIN_NONE, d);
        cyc(0, 0, 1, 0, 0, "point_tick2", POINT, a, b, WIN_NONE, d);
        cyc(0, 0, 1, 0, 0, "point_tick3", SERVE, a, b, WIN_NONE, d);
    endtask

    // Monitor: compare queued expectations against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            snap_t a;
            e = exp_q.pop_front();
            a = {bus.State_o, bus.Score_P1_o, bus.Score_P2_o, bus.Winner_o,
                 bus.Ball_Active_o, bus.Ball_Reset_o, bus.Serve_Dir_o};
            n_checks++;
            if (a === e.s) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %s, required %s", e.name, fmt(a), fmt(e.s));
            end
        end
    end

    initial begin
        // Reset and reset priority over a simultaneous start.
        cyc(1, 0, 0, 0, 0, "reset",       IDLE, 0, 0, WIN_NONE, DIR_P1);
        cyc(1, 1, 1, 1, 1, "reset_hold",  IDLE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 0, 1, 0, 0, "idle_tick",   IDLE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 0, 0, 1, 1, "idle_miss",   IDLE, 0, 0, WIN_NONE, DIR_P1);

        // Start, serve delay with ignored start/miss.
        cyc(0, 1, 0, 0, 0, "start",           SERVE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 0, 1, 0, 0, "serve_t1",        SERVE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 1, 0, 0, 0, "serve_start_ign", SERVE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 0, 0, 1, 0, "serve_miss_ign",  SERVE, 0, 0, WIN_NONE, DIR_P1);
        cyc(0, 0, 1, 0, 0, "serve_t2",        PLAY,  0, 0, WIN_NONE, DIR_P1);
        cyc(0, 1, 1, 0, 0, "play_ign",        PLAY,  0, 0, WIN_NONE, DIR_P1);

        // P2 misses: P1 scores, serve goes right.
        cyc(0, 0, 0, 0, 1, "miss_p2",        POINT, 1, 0, WIN_NONE, DIR_P2);
        cyc(0, 0, 0, 1, 0, "point_miss_ign", POINT, 1, 0, WIN_NONE, DIR_P2);
        cyc(0, 1, 1, 0, 0, "point_t1",       POINT, 1, 0, WIN_NONE, DIR_P2);
        cyc(0, 0, 1, 0, 0, "point_t2",       POINT, 1, 0, WIN_NONE, DIR_P2);
        cyc(0, 0, 1, 0, 0, "point_t3",       SERVE, 1, 0, WIN_NONE, DIR_P2);
        serve_play(1, 0, DIR_P2);

        // Simultaneous misses replay the point.
        cyc(0, 0, 0, 1, 1, "both_miss",      POINT, 1, 0, WIN_NONE, DIR_P2);
        cyc(0, 0, 0, 1, 1, "point_both_ign", POINT, 1, 0, WIN_NONE, DIR_P2);
        point_serve(1, 0, DIR_P2);
        serve_play(1, 0, DIR_P2);

        // P1 misses: P2 scores, serve goes left.
        cyc(0, 0, 0, 1, 0, "miss_p1", POINT, 1, 1, WIN_NONE, DIR_P1);
        point_serve(1, 1, DIR_P1);
        serve_play(1, 1, DIR_P1);
        cyc(0, 0, 0, 0, 1, "miss_p2_b", POINT, 2, 1, WIN_NONE, DIR_P2);
        point_serve(2, 1, DIR_P2);
        serve_play(2, 1, DIR_P2);

        // P1 reaches the win score; OVER holds until restart.
        cyc(0, 0, 0, 0, 1, "win_p1",    OVER, 3, 1, WIN_P1, DIR_P2);
        cyc(0, 0, 1, 1, 1, "over_ign",  OVER, 3, 1, WIN_P1, DIR_P2);
        cyc(0, 0, 1, 1, 0, "over_ign2", OVER, 3, 1, WIN_P1, DIR_P2);
        cyc(0, 1, 0, 0, 0, "restart",   SERVE, 0, 0, WIN_NONE, DIR_P1);
        serve_play(0, 0, DIR_P1);

        // Mid-game reset with P2 on two points.
        cyc(0, 0, 0, 1, 0, "p2_pt1", POINT, 0, 1, WIN_NONE, DIR_P1);
        point_serve(0, 1, DIR_P1);
        serve_play(0, 1, DIR_P1);
        cyc(0, 0, 0, 1, 0, "p2_pt2", POINT, 0, 2, WIN_NONE, DIR_P1);
        point_serve(0, 2, DIR_P1);
        serve_play(0, 2, DIR_P1);
        cyc(1, 0, 0, 0, 0, "rst_mid", IDLE, 0, 0, WIN_NONE, DIR_P1);

        // Fresh game won by P2.
        cyc(0, 1, 0, 0, 0, "start2", SERVE, 0, 0, WIN_NONE, DIR_P1);
        serve_play(0, 0, DIR_P1);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 0, 1, 0, "p2_score", (k == 3) ? OVER : POINT, 0, 4'(k),
                (k == 3) ? WIN_P2 : WIN_NONE, DIR_P1);
            if (k < 3) begin
                point_serve(0, 4'(k), DIR_P1);
                serve_play(0, 4'(k), DIR_P1);
            end
        end
        cyc(0, 0, 1, 0, 1, "over_p2_ign", OVER, 0, 3, WIN_P2, DIR_P1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations unconsumed, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog in case the clock or stimulus stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
